spi_slave_responder: RTL and testbench

//  Synthesizable single-lane SPI slave: the responder end of the SPI master IP's frames.

---
 rtl/pulpino_spi_master_ip_global_pkg.sv | 69 ++++++
 rtl/spi_slave_sync.sv | 36 +++
 rtl/spi_slave_responder.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulpino_spi_master_ip_global_pkg.sv
// Shared types and helpers for the SPI slave responder.
//   spi_slv_state_e : frame phase sequence, IDLE through WAIT_CS
//   spi_slv_frame_s : decoded frame record reported at CS_N release
//   next_phase()    : first phase after 'cur' whose length is non-zero
//   phase_len()     : length (sclk rises) of the given phase
package pulpino_spi_master_ip_global_pkg;

    localparam int FIELD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        WDATA,
        RDATA,
        WAIT_CS
    } spi_slv_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] cmd;
        logic [FIELD_W-1:0] addr;
        logic [FIELD_W-1:0] wdata;
        logic [FIELD_W-1:0] bit_cnt;
        logic               err;
    } spi_slv_frame_s;

    // Zero-length phases are skipped, so the successor is the first later
    // phase with a non-zero length, or WAIT_CS when none is left.
    function automatic spi_slv_state_e next_phase(
        input spi_slv_state_e cur,
        input logic [5:0]     cmd_len,
        input logic [5:0]     addr_len,
        input logic [15:0]    dummy_len,
        input logic [15:0]    wr_len,
        input logic [15:0]    rd_len
    );
        if (cur == IDLE && cmd_len != 6'd0)
            return CMD;
        if ((cur inside {IDLE, CMD}) && addr_len != 6'd0)
            return ADDR;
        if ((cur inside {IDLE, CMD, ADDR}) && dummy_len != 16'd0)
            return DUMMY;
        if ((cur inside {IDLE, CMD, ADDR, DUMMY}) && wr_len != 16'd0)
            return WDATA;
        if ((cur inside {IDLE, CMD, ADDR, DUMMY, WDATA}) && rd_len != 16'd0)
            return RDATA;
        return WAIT_CS;
    endfunction

    function automatic logic [15:0] phase_len(
        input spi_slv_state_e st,
        input logic [5:0]     cmd_len,
        input logic [5:0]     addr_len,
        input logic [15:0]    dummy_len,
        input logic [15:0]    wr_len,
        input logic [15:0]    rd_len
    );
        case (st)
            CMD:     return {10'd0, cmd_len};
            ADDR:    return {10'd0, addr_len};
            DUMMY:   return dummy_len;
            WDATA:   return wr_len;
            RDATA:   return rd_len;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Input synchroniser with edge detection for one SPI pin.
//   clk, rstn : system clock, asynchronous active-low reset
//   din       : asynchronous pin
//   level     : synchronised level
//   rise/fall : 1-clk pulses on synchronised edges
// All flops reset to 0. For cs_n this reads as "selected", so a frame can
// only start after cs_n has first been seen high out of reset.
module spi_slave_sync #(
    parameter int STAGES = 2    // must be >= 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = sync_reg[STAGES-1] & ~prev_reg;
    assign fall  = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave_responder.sv
// Oversampled single-lane SPI slave (mode 0) that decodes cmd/addr/dummy/
// write/read phases and reports one frame record per CS_N window.
//   clk, rstn                 : system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi        : SPI pins (synchronised internally)
//   spi_miso, spi_miso_oe     : read data out and its drive enable
//   cfg_*_len                 : phase lengths, latched at CS_N fall
//   rd_data, rd_req           : read word, sampled when rd_req pulses
//   frame_valid + frame_*     : frame record, held until the next frame
module spi_slave_responder
    import pulpino_spi_master_ip_global_pkg::*;
#(
    parameter int MAX_LEN     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [5:0]  cfg_cmd_len,
    input  logic [5:0]  cfg_addr_len,
    input  logic [15:0] cfg_dummy_len,
    input  logic [15:0] cfg_wr_len,
    input  logic [15:0] cfg_rd_len,
    input  logic [31:0] rd_data,
    output logic        rd_req,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [31:0] frame_cmd,
    output logic [31:0] frame_addr,
    output logic [31:0] frame_wdata,
    output logic [31:0] frame_bit_cnt
);

    // Pin index: 0 = mosi, 1 = sclk, 2 = cs_n
    logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;
    assign pin_raw = {spi_cs_n, spi_sclk, spi_mosi};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rstn  (rstn),
                .din   (pin_raw[gi]),
                .level (pin_lvl[gi]),
                .rise  (pin_rise[gi]),
                .fall  (pin_fall[gi])
            );
        end
    endgenerate

    logic mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign mosi_s    = pin_lvl[0];
    assign sclk_rise = pin_rise[1];
    assign sclk_fall = pin_fall[1];
    assign cs_rise   = pin_rise[2];
    assign cs_fall   = pin_fall[2];

    logic unused_sync;
    assign unused_sync = ^{pin_lvl[2:1], pin_rise[0], pin_fall[0]};

    spi_slv_state_e     state_reg;
    logic [5:0]         cmd_len_reg, addr_len_reg;
    logic [15:0]        dummy_len_reg, wr_len_reg, rd_len_reg;
    logic [MAX_LEN-1:0] cmd_reg, addr_reg, wdata_reg;
    logic [31:0]        bit_cnt_reg;
    logic [15:0]        phase_cnt_reg;
    logic [31:0]        rd_word_reg;
    logic [15:0]        rd_idx_reg;
    logic               rd_first_reg;
    logic               miso_reg, oe_reg, rd_req_reg, frame_valid_reg;
    spi_slv_frame_s     frame_reg;

    spi_slv_state_e start_state, after_state;
    logic [15:0]    cur_len;
    logic           phase_done;

    assign start_state = next_phase(IDLE, cfg_cmd_len, cfg_addr_len,
                                    cfg_dummy_len, cfg_wr_len, cfg_rd_len);
    assign after_state = next_phase(state_reg, cmd_len_reg, addr_len_reg,
                                    dummy_len_reg, wr_len_reg, rd_len_reg);
    assign cur_len     = phase_len(state_reg, cmd_len_reg, addr_len_reg,
                                   dummy_len_reg, wr_len_reg, rd_len_reg);
    assign phase_done  = sclk_rise
                       && (state_reg inside {CMD, ADDR, DUMMY, WDATA, RDATA})
                       && (phase_cnt_reg + 16'd1 == cur_len);

    // Read bits above the 32-bit word are padding zeros.
    function automatic logic rd_bit(input logic [31:0] w, input logic [15:0] i);
        return (i < 16'd32) ? w[i[4:0]] : 1'b0;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            cmd_len_reg     <= '0;
            addr_len_reg    <= '0;
            dummy_len_reg   <= '0;
            wr_len_reg      <= '0;
            rd_len_reg      <= '0;
            cmd_reg         <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            bit_cnt_reg     <= '0;
            phase_cnt_reg   <= '0;
            rd_word_reg     <= '0;
            rd_idx_reg      <= '0;
            rd_first_reg    <= 1'b0;
            miso_reg        <= 1'b0;
            oe_reg          <= 1'b0;
            rd_req_reg      <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_reg       <= '0;
        end else begin
            rd_req_reg      <= 1'b0;
            frame_valid_reg <= 1'b0;

            if (state_reg != IDLE && cs_rise) begin
                // A rise landing on the cs_rise clk is deliberately dropped.
                frame_valid_reg   <= 1'b1;
                frame_reg.cmd     <= 32'(cmd_reg);
                frame_reg.addr    <= 32'(addr_reg);
                frame_reg.wdata   <= 32'(wdata_reg);
                frame_reg.bit_cnt <= bit_cnt_reg;
                frame_reg.err     <= (state_reg != WAIT_CS);
                state_reg         <= IDLE;
                miso_reg          <= 1'b0;
                oe_reg            <= 1'b0;
                rd_first_reg      <= 1'b0;
            end else if (state_reg == IDLE) begin
                if (cs_fall) begin
                    cmd_len_reg   <= cfg_cmd_len;
                    addr_len_reg  <= cfg_addr_len;
                    dummy_len_reg <= cfg_dummy_len;
                    wr_len_reg    <= cfg_wr_len;
                    rd_len_reg    <= cfg_rd_len;
                    cmd_reg       <= '0;
                    addr_reg      <= '0;
                    wdata_reg     <= '0;
                    bit_cnt_reg   <= '0;
                    phase_cnt_reg <= '0;
                    state_reg     <= start_state;
                    if (start_state == RDATA) begin
                        rd_req_reg   <= 1'b1;
                        rd_word_reg  <= rd_data;
                        rd_idx_reg   <= cfg_rd_len - 16'd1;
                        rd_first_reg <= 1'b1;
                    end
                end
            end else if (sclk_rise) begin
                if (bit_cnt_reg != '1)
                    bit_cnt_reg <= bit_cnt_reg + 32'd1;
                case (state_reg)
                    CMD:     cmd_reg   <= {cmd_reg[MAX_LEN-2:0], mosi_s};
                    ADDR:    addr_reg  <= {addr_reg[MAX_LEN-2:0], mosi_s};
                    WDATA:   wdata_reg <= {wdata_reg[MAX_LEN-2:0], mosi_s};
                    default: ;
                endcase
                if (phase_done) begin
                    phase_cnt_reg <= '0;
                    state_reg     <= after_state;
                    if (state_reg == RDATA) begin
                        miso_reg <= 1'b0;
                        oe_reg   <= 1'b0;
                    end
                    if (after_state == RDATA) begin
                        rd_req_reg   <= 1'b1;
                        rd_word_reg  <= rd_data;
                        rd_idx_reg   <= rd_len_reg - 16'd1;
                        rd_first_reg <= 1'b1;
                    end
                end else if (state_reg != WAIT_CS) begin
                    phase_cnt_reg <= phase_cnt_reg + 16'd1;
                end
            end else if (state_reg == RDATA) begin
                if (rd_first_reg) begin
                    miso_reg     <= rd_bit(rd_word_reg, rd_idx_reg);
                    oe_reg       <= 1'b1;
                    rd_first_reg <= 1'b0;
                end else if (sclk_fall && phase_cnt_reg != 16'd0) begin
                    // The fall right after the entry rise belongs to the
                    // previous phase; only falls after a read rise advance.
                    rd_idx_reg <= rd_idx_reg - 16'd1;
                    miso_reg   <= rd_bit(rd_word_reg, rd_idx_reg - 16'd1);
                end
            end
        end
    end

    assign spi_miso      = miso_reg;
    assign spi_miso_oe   = oe_reg;
    assign rd_req        = rd_req_reg;
    assign frame_valid   = frame_valid_reg;
    assign frame_err     = frame_reg.err;
    assign frame_cmd     = frame_reg.cmd;
    assign frame_addr    = frame_reg.addr;
    assign frame_wdata   = frame_reg.wdata;
    assign frame_bit_cnt = frame_reg.bit_cnt;

endmodule

// File: tb/tb_spi_slave_responder.sv
module tb_spi_slave_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [5:0]  cfg_cmd_len, cfg_addr_len;
    logic [15:0] cfg_dummy_len, cfg_wr_len, cfg_rd_len;
    logic [31:0] rd_data;
    logic        rd_req, frame_valid, frame_err;
    logic [31:0] frame_cmd, frame_addr, frame_wdata, frame_bit_cnt;

    always #5 clk = ~clk;

    spi_slave_responder dut (
        .clk           (clk),
        .rstn          (rstn),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .cfg_cmd_len   (cfg_cmd_len),
        .cfg_addr_len  (cfg_addr_len),
        .cfg_dummy_len (cfg_dummy_len),
        .cfg_wr_len    (cfg_wr_len),
        .cfg_rd_len    (cfg_rd_len),
        .rd_data       (rd_data),
        .rd_req        (rd_req),
        .frame_valid   (frame_valid),
        .frame_err     (frame_err),
        .frame_cmd     (frame_cmd),
        .frame_addr    (frame_addr),
        .frame_wdata   (frame_wdata),
        .frame_bit_cnt (frame_bit_cnt)
    );

    int checks     = 0;
    int failures   = 0;
    int fv_cnt     = 0;
    int rdreq_cnt  = 0;
    int rdreq_at   = -1;
    int rises_done = 0;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (rd_req) begin
            rdreq_cnt++;
            rdreq_at = rises_done;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sclk_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            spi_mosi = 1'($urandom_range(1, 0));
            repeat (6) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (6) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    // One complete master transaction. The expected record is worked out
    // from the bit stream sent: cmd/addr/wdata are the most recent 32 bits
    // seen in each field's window, bit_cnt is the number of rises, err means
    // cs_n rose before every configured bit was clocked.
    task automatic run_frame(
        input string       name,
        input int          cl, input int al, input int dl, input int wl, input int rl,
        input logic [63:0] cmd_v, input logic [63:0] addr_v, input logic [63:0] wdata_v,
        input logic [31:0] rdv, input int n, input bit rnd,
        output logic [63:0] rd_seen
    );
        bit          q[$];
        int          total, rd_start, lat, oe_bad, i;
        bit          in_rd;
        logic [31:0] e_cmd, e_addr, e_wd;
        logic [63:0] e_rd, o_rd;
        int          e_rdreq;

        total    = cl + al + dl + wl + rl;
        rd_start = cl + al + dl + wl;
        for (int b = cl - 1; b >= 0; b--)
            q.push_back(rnd ? 1'($urandom_range(1, 0)) : (b < 64 ? cmd_v[b] : 1'b0));
        for (int b = al - 1; b >= 0; b--)
            q.push_back(rnd ? 1'($urandom_range(1, 0)) : (b < 64 ? addr_v[b] : 1'b0));
        for (int b = 0; b < dl; b++)
            q.push_back(1'($urandom_range(1, 0)));
        for (int b = wl - 1; b >= 0; b--)
            q.push_back(rnd ? 1'($urandom_range(1, 0)) : (b < 64 ? wdata_v[b] : 1'b0));
        while (q.size() < n || q.size() < total)
            q.push_back(1'($urandom_range(1, 0)));

        e_cmd = '0; e_addr = '0; e_wd = '0;
        for (int k = 0; k < n; k++) begin
            if (k < cl)                     e_cmd  = {e_cmd[30:0], q[k]};
            else if (k < cl + al)           e_addr = {e_addr[30:0], q[k]};
            else if (k < cl + al + dl)      ;
            else if (k < rd_start)          e_wd   = {e_wd[30:0], q[k]};
        end
        e_rdreq = (rl != 0 && n >= rd_start) ? 1 : 0;

        cfg_cmd_len   = 6'(cl);
        cfg_addr_len  = 6'(al);
        cfg_dummy_len = 16'(dl);
        cfg_wr_len    = 16'(wl);
        cfg_rd_len    = 16'(rl);
        rd_data       = rdv;
        rdreq_cnt = 0; rdreq_at = -1; rises_done = 0;
        oe_bad = 0; o_rd = '0; e_rd = '0;

        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (12) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            spi_mosi = q[k];
            repeat (6) @(negedge clk);
            in_rd = (k >= rd_start) && (k < rd_start + rl);
            if (spi_miso_oe !== in_rd) oe_bad++;
            if (in_rd) begin
                i    = rl - 1 - (k - rd_start);
                o_rd = {o_rd[62:0], spi_miso};
                e_rd = {e_rd[62:0], (i < 32) ? rdv[i] : 1'b0};
            end
            spi_sclk = 1'b1;
            rises_done++;
            repeat (6) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        spi_cs_n = 1'b1;

        lat = 0;
        for (int w = 1; w <= 12; w++) begin
            @(negedge clk);
            if (frame_valid) begin
                lat = w;
                break;
            end
        end
        chk({name, ".latency"}, 64'(lat), 64'd3);
        chk({name, ".cmd"},     64'(frame_cmd),     64'(e_cmd));
        chk({name, ".addr"},    64'(frame_addr),    64'(e_addr));
        chk({name, ".wdata"},   64'(frame_wdata),   64'(e_wd));
        chk({name, ".bit_cnt"}, 64'(frame_bit_cnt), 64'(n));
        chk({name, ".err"},     64'(frame_err),     64'(n < total));
        @(negedge clk);
        chk({name, ".valid_pulse"}, 64'(frame_valid), 64'd0);
        chk({name, ".rd_req_cnt"},  64'(rdreq_cnt),   64'(e_rdreq));
        if (e_rdreq != 0)
            chk({name, ".rd_req_at"}, 64'(rdreq_at), 64'(rd_start));
        chk({name, ".oe_window"}, 64'(oe_bad), 64'd0);
        chk({name, ".miso_data"}, o_rd, e_rd);
        chk({name, ".idle_oe_miso"}, {62'd0, spi_miso_oe, spi_miso}, 64'd0);
        $display("frame %s: cl=%0d al=%0d dl=%0d wl=%0d rl=%0d rises=%0d cmd=%h addr=%h wdata=%h err=%0d rd=%h",
                 name, cl, al, dl, wl, rl, n, frame_cmd, frame_addr, frame_wdata, frame_err, o_rd);
        rd_seen = o_rd;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [63:0] rd_seen;
        int          fv0, cl, al, dl, wl, rl, tot, n, mode;

        rstn = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        cfg_cmd_len = '0; cfg_addr_len = '0; cfg_dummy_len = '0;
        cfg_wr_len = '0; cfg_rd_len = '0; rd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset.outputs", {frame_cmd, frame_bit_cnt}, 64'd0);
        chk("reset.flags", {59'd0, spi_miso, spi_miso_oe, rd_req, frame_valid, frame_err}, 64'd0);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        chk("reset.no_frame", 64'(fv_cnt), 64'd0);

        run_frame("t1_write", 8, 24, 0, 32, 0, 64'h02, 64'h001000, 64'hDEADBEEF, 32'h0, 64, 1'b0, rd_seen);
        chk("t1.cmd_lit",   64'(frame_cmd),   64'h02);
        chk("t1.addr_lit",  64'(frame_addr),  64'h001000);
        chk("t1.wdata_lit", 64'(frame_wdata), 64'hDEADBEEF);

        run_frame("t1_waitcs", 8, 24, 0, 32, 0, 64'h3C, 64'h00ABCD, 64'h01234567, 32'h0, 70, 1'b0, rd_seen);

        run_frame("t2_read", 8, 24, 8, 0, 32, 64'h0B, 64'h0, 64'h0, 32'hA5A50F0F, 72, 1'b0, rd_seen);
        chk("t2.rd_lit", rd_seen, 64'hA5A50F0F);

        run_frame("t3_rd40", 0, 0, 0, 0, 40, 64'h0, 64'h0, 64'h0, 32'h12345678, 40, 1'b0, rd_seen);
        chk("t3.rd_lit", rd_seen, 64'h0012345678);

        run_frame("t4_short", 8, 24, 0, 0, 0, 64'h9F, 64'hABCDEF, 64'h0, 32'h0, 12, 1'b0, rd_seen);
        chk("t4.err_lit",  64'(frame_err),  64'd1);
        chk("t4.addr_lit", 64'(frame_addr), 64'hA);

        run_frame("t5_empty", 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 32'hFFFFFFFF, 5, 1'b0, rd_seen);
        chk("t5.bit_cnt_lit", 64'(frame_bit_cnt), 64'd5);

        // Asynchronous reset in the middle of the address phase.
        cfg_cmd_len = 6'd8; cfg_addr_len = 6'd24; cfg_dummy_len = '0;
        cfg_wr_len = '0; cfg_rd_len = '0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (12) @(negedge clk);
        sclk_pulses(12);
        rstn = 1'b0;
        #1;
        chk("t6.reset_fields", {frame_cmd, frame_bit_cnt}, 64'd0);
        chk("t6.reset_flags", {59'd0, spi_miso, spi_miso_oe, rd_req, frame_valid, frame_err}, 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        fv0 = fv_cnt;
        repeat (4) @(negedge clk);
        sclk_pulses(4);
        repeat (6) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6.no_frame", 64'(fv_cnt), 64'(fv0));
        run_frame("t6_after", 8, 24, 0, 16, 0, 64'h5A, 64'h123456, 64'hBEEF, 32'h0, 48, 1'b0, rd_seen);

        // Randomized frames: lengths beyond 32 exercise capture clipping and
        // read padding; some frames are cut short, some overrun into WAIT_CS.
        for (int r = 0; r < 8; r++) begin
            cl = $urandom_range(40, 0);
            al = $urandom_range(40, 0);
            dl = $urandom_range(6, 0);
            wl = $urandom_range(40, 0);
            rl = $urandom_range(40, 0);
            tot  = cl + al + dl + wl + rl;
            mode = $urandom_range(2, 0);
            if (mode == 0)      n = tot;
            else if (mode == 1) n = tot + $urandom_range(5, 1);
            else                n = (tot > 0) ? $urandom_range(tot, 0) : 3;
            run_frame($sformatf("rnd%0d", r), cl, al, dl, wl, rl,
                      64'h0, 64'h0, 64'h0, $urandom, n, 1'b1, rd_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
